// File: rtl/clk_rst_sequencer.sv
// Power-up/recovery sequencer for the MMCM: resets the MMCM, qualifies lock, then releases
// the peripheral and TPU core resets in order. Define LOCK_LOSS_RECOVER_EN to auto-resequence on lock loss.
module clk_rst_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned STABLE_CYCLES   = 256,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       soft_rst_req,
  output logic       mmcm_rst,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       sys_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

`ifdef LOCK_LOSS_RECOVER_EN
  localparam state_e LOSS_STATE = ST_HOLD;
`else
  localparam state_e LOSS_STATE = ST_FAULT;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             sync1_q, sync2_q;
  logic             locked_s;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             periph_rst_n_q, periph_rst_n_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             sys_ready_q, sys_ready_d;
  logic             fault_q, fault_d;

  assign locked_s = sync2_q;

  // State register, counters, synchronizer and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      retry_q        <= '0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      mmcm_rst_q     <= 1'b1;
      periph_rst_n_q <= 1'b0;
      core_rst_n_q   <= 1'b0;
      sys_ready_q    <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      sync1_q        <= mmcm_locked;
      sync2_q        <= sync1_q;
      mmcm_rst_q     <= mmcm_rst_d;
      periph_rst_n_q <= periph_rst_n_d;
      core_rst_n_q   <= core_rst_n_d;
      sys_ready_q    <= sys_ready_d;
      fault_q        <= fault_d;
    end
  end

  // Next-state logic; soft_rst_req overrides every other event.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (soft_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_HOLD;
              retry_d = retry_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A dropout restarts the full lock-timeout window.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!locked_s) begin
            state_d = LOSS_STATE;
            cnt_d   = '0;
          end else if (cnt_q == GAP_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = LOSS_STATE;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state itself.
  always_comb begin
    mmcm_rst_d     = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    periph_rst_n_d = (state_d == ST_RELEASE) || (state_d == ST_RUN);
    core_rst_n_d   = (state_d == ST_RUN);
    sys_ready_d    = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  assign mmcm_rst     = mmcm_rst_q;
  assign periph_rst_n = periph_rst_n_q;
  assign core_rst_n   = core_rst_n_q;
  assign sys_ready    = sys_ready_q;
  assign fault        = fault_q;
  assign retry_cnt    = retry_q;
  assign state_dbg    = state_q;

endmodule
